// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC transmit arbiter: index widths, tagged beat layout, lock states.
package cdc_pkg;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  // Beat layout: payload from PAYLOAD_LSB upward, source tag directly above it (MSBs).
  localparam int PAYLOAD_LSB = 0;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, modulo N. Purely combinational.
module rr_pick
  import cdc_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] w_rot;
  int           w_sum;

  always_comb begin
    // Rotating the doubled vector right by ptr puts req[ptr] at bit 0.
    w_rot = N'({req, req} >> ptr);
    any   = |req;
    idx   = '0;
    w_sum = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = int'(ptr) + k;
        idx   = IDW'((w_sum >= N) ? (w_sum - N) : w_sum);
      end
    end
  end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Locking round-robin arbiter feeding a registered, source-tagged beat into a CDC FIFO write port.
// One cycle from accept to out_valid; a stalled output holds out_data and deasserts every in_ready.
module cdc_tx_arbiter
  import cdc_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [IDW+WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 locked,
  output logic [IDW-1:0]       lock_id
);

  lock_state_e          r_state;
  lock_state_e          w_state_nxt;
  logic [IDW-1:0]       r_lock_id;
  logic [IDW-1:0]       w_lock_id_nxt;
  logic [IDW-1:0]       r_rr_ptr;
  logic [IDW-1:0]       w_rr_ptr_nxt;
  logic                 r_out_valid;
  logic [IDW+WIDTH-1:0] r_out_data;

  logic                 w_pick_any;
  logic [IDW-1:0]       w_pick_idx;
  logic                 w_can_load;
  logic [IDW-1:0]       w_cand;
  logic                 w_cand_vld;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_payload;
  logic [IDW+WIDTH-1:0] w_beat;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req (in_valid),
    .ptr (r_rr_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  always_comb begin
    w_can_load = ~r_out_valid | out_ready;
    w_cand     = (r_state == LK_LOCKED) ? r_lock_id : w_pick_idx;
    w_cand_vld = (r_state == LK_LOCKED) ? in_valid[r_lock_id] : w_pick_any;
    w_accept   = w_can_load & ~reset & w_cand_vld;
    w_payload  = in_data[int'(w_cand)*WIDTH +: WIDTH];

    w_beat                                 = '0;
    w_beat[PAYLOAD_LSB +: WIDTH]           = w_payload;
    w_beat[PAYLOAD_LSB + WIDTH +: IDW]     = w_cand;

    in_ready = '0;
    if (w_accept) in_ready[w_cand] = 1'b1;

    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (w_accept) begin
      // Pointer advances on locked beats too, so the holder goes last once it releases.
      w_rr_ptr_nxt = (int'(w_cand) == N - 1) ? '0 : w_cand + 1'b1;
      if (in_last[w_cand]) begin
        w_state_nxt = LK_IDLE;
      end else begin
        w_state_nxt   = LK_LOCKED;
        w_lock_id_nxt = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LK_IDLE;
      r_lock_id   <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign locked    = (r_state == LK_LOCKED);
  assign lock_id   = r_lock_id;

endmodule

// File: doc/cdc_tx_arbiter.md
Name: cdc_tx_arbiter

Overview:
- Round-robin arbiter that shares the write port of a one-deep async CDC FIFO among N requesters in the write-clock domain.
- Each accepted beat is registered and prefixed with the source index, so the read domain can demultiplex.
- Multi-beat messages are supported: a grant locks to one requester from its first beat until its beat with in_last set is accepted.
- Sits between local producers and the FIFO wr_valid/wr_data/wr_ready port; out_ready connects to the FIFO wr_ready.

Parameters:
- N, 4, number of requesters (1..16).
- WIDTH, 16, payload bits per beat.
- IDW, (N>1 ? $clog2(N) : 1), width of the source-index tag.

Ports:
- clk  input  1  write-domain clock; all logic is on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-requester beat valid.
- in_data  input  N*WIDTH  payloads; requester i uses bits [i*WIDTH +: WIDTH].
- in_last  input  N  marks the final beat of a message; a single-beat message has in_last=1.
- in_ready  output  N  per-requester accept, one-hot or zero.
- out_valid  output  1  registered beat available to the FIFO.
- out_data  output  IDW+WIDTH  {source index, payload}, registered.
- out_ready  input  1  FIFO wr_ready.
- locked  output  1  registered; a multi-beat message is in progress.
- lock_id  output  IDW  registered; requester that holds the lock.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, locked=0, lock_id=0, rr_ptr=0.
  - in_ready is 0 during any cycle in which reset=1.
- Output register:
  - can_load = ~out_valid | out_ready.
  - A beat transfers on the output when out_valid & out_ready.
  - Drain and load may happen in the same cycle, giving 1 beat/cycle peak throughput.
  - While out_valid=1 and out_ready=0, out_data is held stable.
- Arbitration (combinational, evaluated each cycle):
  - If locked, the candidate is lock_id only.
  - Otherwise the candidate is the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N.
- Accept:
  - in_ready[g] = can_load & ~reset & in_valid[g] for the candidate g; all other in_ready bits are 0.
  - in_ready depends combinationally on in_valid; requesters must not make in_valid depend on in_ready.
- On accept of requester g at posedge:
  - out_valid<=1 and out_data<={g, payload_g}.
  - rr_ptr<=(g+1) mod N, updated on every accepted beat including locked beats.
  - If in_last[g]=0: locked<=1, lock_id<=g.
  - If in_last[g]=1: locked<=0.
- With no accept and an output drain: out_valid<=0.
- Lock state machine:
  - States: IDLE (locked=0) and LOCKED (locked=1).
  - IDLE->LOCKED on an accept with in_last=0.
  - LOCKED->IDLE on an accept from lock_id with in_last=1.
  - While LOCKED, if in_valid[lock_id]=0 nothing is granted and other requesters stall. There is no timeout.
- Fairness: with all N requesters continuously valid and single-beat messages, the grant order is 0,1,...,N-1,0,...
- N=1: rr_ptr is constant 0; the tag is a 1-bit 0.
- Reset asserted mid-message or with out_valid=1: the pending beat is discarded and the lock is cleared on the next edge. The downstream consumer must tolerate a truncated message.
- Index arithmetic is modulo N for any N, not only powers of two. rr_ptr is IDW bits wide and never holds a value ≥N.

Decomposition:
- Shared package cdc_pkg: index-width function clog2_min1(n), and a localparam for the tagged beat layout (tag in the MSBs).
- One natural sub-module, rr_pick:
  - Combinational.
  - Inputs: req[N], ptr[IDW].
  - Outputs: any, idx[IDW].
  - Implemented as a double-width rotate-and-priority-encode.
  - Unit-tested on its own.
- The top level holds the output register and the lock FSM.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with all in_valid=1 -> in_ready=0 and out_valid=0 throughout reset. On the first cycle after reset, out_valid=1 with tag 0.
- Round robin: N=4, in_valid=4'b1111, in_last=all 1, out_ready=1 -> tags 0,1,2,3,0,1 on consecutive cycles, one beat per cycle.
- Lock:
  - Stimulus: requester 2 sends payloads 0xA0,0xA1,0xA2 with last on 0xA2 while requester 1 is continuously valid.
  - Required response: out_data = {2,A0},{2,A1},{2,A2},{1,..}; locked=1 after the first beat and 0 after the third.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with requester 3 valid, payload 0x1234.
  - Required response: out_valid=1, out_data={3,0x1234} stable for all 5 cycles, in_ready=0 after the first accept. The beat is delivered exactly once when out_ready=1.
- Lock stall: requester 0 locked and then drops in_valid for 3 cycles while requester 1 is valid -> no in_ready pulses, out_valid falls after the drain, locked stays 1.
- Reset mid-lock: assert reset while locked=1, lock_id=2 -> next cycle locked=0, out_valid=0. After release, requester 1 (valid) is granted with tag 1.
